// File: rtl/seq_scan_if.sv
// Requester-side bus of seq_scan_arbiter: request/word inputs, grant and scan-result outputs.
// SEQ_SCAN_ABORT_EN adds the abort strobe driven by the requester side.
interface seq_scan_if #(
    parameter int NREQ   = 2,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,
    parameter int ID_W   = 3
);
    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] data;
`ifdef SEQ_SCAN_ABORT_EN
    logic                   abort;
`endif
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   det_bit;
    logic                   det_hit;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [CNT_W-1:0]       match_cnt;

    modport master (
`ifdef SEQ_SCAN_ABORT_EN
        output abort,
`endif
        output req, data,
        input  gnt, busy, det_bit, det_hit, done, done_id, match_cnt
    );

    modport slave (
`ifdef SEQ_SCAN_ABORT_EN
        input  abort,
`endif
        input  req, data,
        output gnt, busy, det_bit, det_hit, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter feeding granted words MSB-first into an overlapping pattern matcher.
// Optional feature: SEQ_SCAN_ABORT_EN (abort input cancels a scan in progress).
module seq_scan_arbiter #(
    parameter int                  NREQ    = 2,
    parameter int                  WORD_W  = 8,
    parameter int                  PAT_W   = 4,
    parameter logic [PAT_W-1:0]    PATTERN = PAT_W'(4'b1101),
    parameter int                  CNT_W   = 4,
    parameter int                  ID_W    = 3
) (
    input  logic        clk,
    input  logic        clr,
    seq_scan_if.slave   bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int K_W   = $clog2(WORD_W);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD_W-1:0]  r_word;
    logic [K_W-1:0]     r_k;
    logic [PAT_W-2:0]   r_hist;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_win;
    logic               w_found;
    logic [ID_W-1:0]    r_done_id;
    logic [CNT_W-1:0]   r_match_cnt;
    logic [PAT_W-1:0]   w_window;
    logic               w_hit;
    logic               w_last;
    logic               w_abort;
    logic [NREQ-1:0]    w_gnt;
    logic               w_busy;
    logic               w_det_bit;
    logic               w_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef SEQ_SCAN_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // Search starts just above the last winner, so a waiting requester is served before a repeat.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_win   = '0;
        j       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            j = int'(r_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!w_found && bus.req[j]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(j);
            end
        end
    end

    assign w_window  = {r_hist, r_word[WORD_W-1]};
    assign w_hit     = (r_state == S_SHIFT) && (r_k >= K_W'(PAT_W-1)) && (w_window == PATTERN);
    assign w_last    = (r_k == K_W'(WORD_W-1));
    assign w_cnt_nxt = w_hit ? sat_inc(r_cnt) : r_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_abort)     w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt     = '0;
        w_busy    = (r_state != S_IDLE);
        w_det_bit = 1'b0;
        w_done    = (r_state == S_DONE);
        if (r_state == S_SHIFT) begin
            w_det_bit = r_word[WORD_W-1];
            if (r_k == '0) w_gnt[r_ptr] = 1'b1;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.busy      = w_busy;
    assign bus.det_bit   = w_det_bit;
    assign bus.det_hit   = w_hit;
    assign bus.done      = w_done;
    assign bus.done_id   = r_done_id;
    assign bus.match_cnt = r_match_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_k         <= '0;
            r_hist      <= '0;
            r_cnt       <= '0;
            r_ptr       <= PTR_W'(NREQ-1);
            r_done_id   <= '0;
            r_match_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ptr  <= w_win;
                        r_k    <= '0;
                        r_hist <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_abort) begin
                        r_k    <= '0;
                        r_hist <= '0;
                        r_cnt  <= '0;
                    end else begin
                        r_k    <= r_k + 1'b1;
                        r_hist <= w_window[PAT_W-2:0];
                        r_cnt  <= w_cnt_nxt;
                        if (w_last) begin
                            r_done_id   <= ID_W'(r_ptr);
                            r_match_cnt <= w_cnt_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Word shifter carries no reset: its contents are only observed while in SHIFT.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_found)
            r_word <= bus.data[int'(w_win)*WORD_W +: WORD_W];
        else if (r_state == S_SHIFT)
            r_word <= {r_word[WORD_W-2:0], 1'b0};
    end
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed bench for seq_scan_arbiter: default instance plus a CNT_W=1 instance for saturation.
// Runs the abort scenario only when SEQ_SCAN_ABORT_EN is defined.
module tb_seq_scan_arbiter;
    logic clk;
    logic clr;
    int   n_pass;
    int   n_total;

    seq_scan_if #(.NREQ(2), .WORD_W(8), .CNT_W(4), .ID_W(3)) bus0 ();
    seq_scan_if #(.NREQ(2), .WORD_W(8), .CNT_W(1), .ID_W(3)) bus1 ();

    seq_scan_arbiter #(.NREQ(2), .WORD_W(8), .PAT_W(4), .PATTERN(4'b1101), .CNT_W(4), .ID_W(3))
        dut0 (.clk(clk), .clr(clr), .bus(bus0));
    seq_scan_arbiter #(.NREQ(2), .WORD_W(8), .PAT_W(4), .PATTERN(4'b1101), .CNT_W(1), .ID_W(3))
        dut1 (.clk(clk), .clr(clr), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        clr = 1'b1;
        bus0.req = '0; bus0.data = '0;
        bus1.req = '0; bus1.data = '0;
`ifdef SEQ_SCAN_ABORT_EN
        bus0.abort = 1'b0; bus1.abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_total++; if (bus0.gnt !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", bus0.gnt); else n_pass++;
        n_total++; if (bus0.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus0.busy); else n_pass++;
        n_total++; if (bus0.det_bit !== 1'b0) $display("FAIL reset_det_bit got=%b exp=0", bus0.det_bit); else n_pass++;
        n_total++; if (bus0.det_hit !== 1'b0) $display("FAIL reset_det_hit got=%b exp=0", bus0.det_hit); else n_pass++;
        n_total++; if (bus0.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus0.done); else n_pass++;
        n_total++; if (bus0.done_id !== 3'd0) $display("FAIL reset_done_id got=%0d exp=0", bus0.done_id); else n_pass++;
        n_total++; if (bus0.match_cnt !== 4'd0) $display("FAIL reset_match_cnt got=%0d exp=0", bus0.match_cnt); else n_pass++;
        n_total++; if (bus1.match_cnt !== 1'd0) $display("FAIL reset_match_cnt1 got=%0d exp=0", bus1.match_cnt); else n_pass++;
        clr = 1'b0;
        @(negedge clk);
        n_total++; if (bus0.busy !== 1'b0) $display("FAIL idle_no_req_busy got=%b exp=0", bus0.busy); else n_pass++;
    endtask

    // Single ch0 scan with per-bit expectations; starts and ends at a negedge in IDLE.
    task automatic test_pattern(input string nm, input logic [7:0] w, input logic [7:0] mask, input logic [3:0] cnt);
        logic [1:0] eg;
        bus0.data[7:0] = w;
        bus0.req = 2'b01;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            eg = (k == 0) ? 2'b01 : 2'b00;
            n_total++; if (bus0.gnt !== eg) $display("FAIL %s_gnt k=%0d got=%b exp=%b", nm, k, bus0.gnt, eg); else n_pass++;
            n_total++; if (bus0.det_bit !== w[7-k]) $display("FAIL %s_det_bit k=%0d got=%b exp=%b", nm, k, bus0.det_bit, w[7-k]); else n_pass++;
            n_total++; if (bus0.det_hit !== mask[k]) $display("FAIL %s_det_hit k=%0d got=%b exp=%b", nm, k, bus0.det_hit, mask[k]); else n_pass++;
            if (k == 0) bus0.req = 2'b00;
            @(negedge clk);
        end
        n_total++; if (bus0.done !== 1'b1) $display("FAIL %s_done got=%b exp=1", nm, bus0.done); else n_pass++;
        n_total++; if (bus0.busy !== 1'b1) $display("FAIL %s_busy_done got=%b exp=1", nm, bus0.busy); else n_pass++;
        n_total++; if (bus0.done_id !== 3'd0) $display("FAIL %s_done_id got=%0d exp=0", nm, bus0.done_id); else n_pass++;
        n_total++; if (bus0.match_cnt !== cnt) $display("FAIL %s_match_cnt got=%0d exp=%0d", nm, bus0.match_cnt, cnt); else n_pass++;
        @(negedge clk);
        n_total++; if (bus0.done !== 1'b0) $display("FAIL %s_done_pulse got=%b exp=0", nm, bus0.done); else n_pass++;
        n_total++; if (bus0.busy !== 1'b0) $display("FAIL %s_busy_after got=%b exp=0", nm, bus0.busy); else n_pass++;
        n_total++; if (bus0.match_cnt !== cnt) $display("FAIL %s_cnt_hold got=%0d exp=%0d", nm, bus0.match_cnt, cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        bus0.data = {8'b11010000, 8'hFF};
        bus0.req = 2'b11;
        @(negedge clk);
        n_total++; if (bus0.gnt !== 2'b01) $display("FAIL b2b_first_gnt got=%b exp=01", bus0.gnt); else n_pass++;
        bus0.req = 2'b10;
        repeat (8) @(negedge clk);
        n_total++; if (bus0.done !== 1'b1) $display("FAIL b2b_done0 got=%b exp=1", bus0.done); else n_pass++;
        n_total++; if (bus0.done_id !== 3'd0) $display("FAIL b2b_done_id0 got=%0d exp=0", bus0.done_id); else n_pass++;
        n_total++; if (bus0.match_cnt !== 4'd0) $display("FAIL b2b_cnt0 got=%0d exp=0", bus0.match_cnt); else n_pass++;
        @(negedge clk);
        n_total++; if (bus0.gnt !== 2'b00) $display("FAIL b2b_gap_gnt got=%b exp=00", bus0.gnt); else n_pass++;
        n_total++; if (bus0.busy !== 1'b0) $display("FAIL b2b_gap_busy got=%b exp=0", bus0.busy); else n_pass++;
        @(negedge clk);
        n_total++; if (bus0.gnt !== 2'b10) $display("FAIL b2b_second_gnt got=%b exp=10", bus0.gnt); else n_pass++;
        bus0.req = 2'b00;
        repeat (8) @(negedge clk);
        n_total++; if (bus0.done !== 1'b1) $display("FAIL b2b_done1 got=%b exp=1", bus0.done); else n_pass++;
        n_total++; if (bus0.done_id !== 3'd1) $display("FAIL b2b_done_id1 got=%0d exp=1", bus0.done_id); else n_pass++;
        n_total++; if (bus0.match_cnt !== 4'd1) $display("FAIL b2b_cnt1 got=%0d exp=1", bus0.match_cnt); else n_pass++;
        @(negedge clk);
        bus0.req = 2'b11;
        @(negedge clk);
        n_total++; if (bus0.gnt !== 2'b01) $display("FAIL rr_wrap_gnt got=%b exp=01", bus0.gnt); else n_pass++;
        bus0.req = 2'b10;
        repeat (8) @(negedge clk);
        n_total++; if (bus0.done_id !== 3'd0) $display("FAIL rr_wrap_done_id got=%0d exp=0", bus0.done_id); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (bus0.gnt !== 2'b10) $display("FAIL rr_fair_gnt got=%b exp=10", bus0.gnt); else n_pass++;
        bus0.req = 2'b00;
        repeat (8) @(negedge clk);
        n_total++; if (bus0.done_id !== 3'd1) $display("FAIL rr_fair_done_id got=%0d exp=1", bus0.done_id); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        bus1.data[7:0] = 8'b11011011;
        bus1.req = 2'b01;
        @(negedge clk);
        n_total++; if (bus1.gnt !== 2'b01) $display("FAIL sat_gnt got=%b exp=01", bus1.gnt); else n_pass++;
        bus1.req = 2'b00;
        repeat (8) @(negedge clk);
        n_total++; if (bus1.done !== 1'b1) $display("FAIL sat_done got=%b exp=1", bus1.done); else n_pass++;
        n_total++; if (bus1.match_cnt !== 1'b1) $display("FAIL sat_match_cnt got=%0d exp=1", bus1.match_cnt); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_clr_midscan();
        bus0.data = {8'b01101101, 8'b11011011};
        bus0.req = 2'b01;
        @(negedge clk);
        bus0.req = 2'b00;
        repeat (4) @(negedge clk);
        n_total++; if (bus0.det_bit !== 1'b1) $display("FAIL clr_pre_det_bit got=%b exp=1", bus0.det_bit); else n_pass++;
        clr = 1'b1;
        #1;
        n_total++; if (bus0.gnt !== 2'b00) $display("FAIL clr_gnt got=%b exp=00", bus0.gnt); else n_pass++;
        n_total++; if (bus0.busy !== 1'b0) $display("FAIL clr_busy got=%b exp=0", bus0.busy); else n_pass++;
        n_total++; if (bus0.det_bit !== 1'b0) $display("FAIL clr_det_bit got=%b exp=0", bus0.det_bit); else n_pass++;
        n_total++; if (bus0.det_hit !== 1'b0) $display("FAIL clr_det_hit got=%b exp=0", bus0.det_hit); else n_pass++;
        n_total++; if (bus0.done_id !== 3'd0) $display("FAIL clr_done_id got=%0d exp=0", bus0.done_id); else n_pass++;
        n_total++; if (bus0.match_cnt !== 4'd0) $display("FAIL clr_match_cnt got=%0d exp=0", bus0.match_cnt); else n_pass++;
        @(negedge clk);
        n_total++; if (bus0.done !== 1'b0) $display("FAIL clr_no_done got=%b exp=0", bus0.done); else n_pass++;
        clr = 1'b0;
        bus0.req = 2'b10;
        @(negedge clk);
        n_total++; if (bus0.gnt !== 2'b10) $display("FAIL clr_after_gnt got=%b exp=10", bus0.gnt); else n_pass++;
        bus0.req = 2'b00;
        repeat (8) @(negedge clk);
        n_total++; if (bus0.done !== 1'b1) $display("FAIL clr_after_done got=%b exp=1", bus0.done); else n_pass++;
        n_total++; if (bus0.done_id !== 3'd1) $display("FAIL clr_after_done_id got=%0d exp=1", bus0.done_id); else n_pass++;
        n_total++; if (bus0.match_cnt !== 4'd2) $display("FAIL clr_after_cnt got=%0d exp=2", bus0.match_cnt); else n_pass++;
        @(negedge clk);
    endtask

`ifdef SEQ_SCAN_ABORT_EN
    task automatic test_abort();
        bus0.data = {8'b11010000, 8'b11011011};
        bus0.req = 2'b01;
        @(negedge clk);
        n_total++; if (bus0.gnt !== 2'b01) $display("FAIL abort_gnt got=%b exp=01", bus0.gnt); else n_pass++;
        bus0.req = 2'b00;
        repeat (2) @(negedge clk);
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        n_total++; if (bus0.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus0.busy); else n_pass++;
        n_total++; if (bus0.done !== 1'b0) $display("FAIL abort_done got=%b exp=0", bus0.done); else n_pass++;
        n_total++; if (bus0.done_id !== 3'd1) $display("FAIL abort_done_id got=%0d exp=1", bus0.done_id); else n_pass++;
        n_total++; if (bus0.match_cnt !== 4'd2) $display("FAIL abort_match_cnt got=%0d exp=2", bus0.match_cnt); else n_pass++;
        bus0.req = 2'b11;
        @(negedge clk);
        n_total++; if (bus0.gnt !== 2'b10) $display("FAIL abort_next_gnt got=%b exp=10", bus0.gnt); else n_pass++;
        bus0.req = 2'b00;
        repeat (8) @(negedge clk);
        n_total++; if (bus0.done_id !== 3'd1) $display("FAIL abort_next_done_id got=%0d exp=1", bus0.done_id); else n_pass++;
        n_total++; if (bus0.match_cnt !== 4'd1) $display("FAIL abort_next_cnt got=%0d exp=1", bus0.match_cnt); else n_pass++;
        @(negedge clk);
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_pattern("pat_db", 8'b11011011, 8'h48, 4'd2);
        test_pattern("pat_zero", 8'h00, 8'h00, 4'd0);
        test_pattern("pat_tail", 8'b00000110, 8'h00, 4'd0);
        test_pattern("pat_nospan", 8'b10100000, 8'h00, 4'd0);
        test_pattern("pat_last", 8'b11011101, 8'h88, 4'd2);
        test_back_to_back();
        test_saturate();
        test_clr_midscan();
`ifdef SEQ_SCAN_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
